uart_host: RTL and testbench
============================

UART_HOST -- requirements
Module: uart_host

Interface
REQ-001 SHALL have parameter AW, default 16, the word-address and count width of both memory ports.
REQ-002 SHALL have parameter IDLE_GAP, default 1, the number of idle-high bit cycles sent after each transmitted word; legal range 1..15.
REQ-003 SHALL have parameter TIMEOUT, default 64, the number of consecutive idle-high cycles that ends a receive burst.
REQ-004 SHALL have ports, one per line: clk  in  1  system clock, all logic on posedge; reset is asynchronous and active-low.
REQ-005 nrst  in  1  asynchronous active-low reset.
REQ-006 start  in  1  one-cycle pulse; starts a transmit burst.
REQ-007 txlen  in  AW  number of words to send, sampled when start is accepted.
REQ-008 txaddr  out  AW  word index into the transmit source memory.
REQ-009 txdata  in  32  source word, combinationally valid for the current txaddr.
REQ-010 datao  out  1  serial line to the SoC datai pin; idle level 1.
REQ-011 datai  in  1  serial line from the SoC datao pin; idle level 1.
REQ-012 rxwe, rxaddr[AW], rxdata[32]  out  sink-memory write strobe, word address and data.
REQ-013 busy, txdone, rxdone, rxerr  out  1 each  transmit active; end-of-transmit pulse; end-of-receive pulse; sticky receive error.
REQ-014 rxcount  out  AW  number of words written in the last completed receive burst.

Function -- transmit
REQ-015 SHALL accept start only while busy=0; a start pulse while busy=1 SHALL be ignored, and an accepted start SHALL clear rxerr.
REQ-016 SHALL, for txlen=0, pulse txdone in the cycle after start is accepted, send no frames, and leave busy=0.
REQ-017 SHALL latch txdata[txaddr] into the word shifter on the edge that begins byte 0 of each word; txaddr SHALL start at 0 and increment after each latch.
REQ-018 SHALL send each byte as a 10-cycle frame, one bit per clock: start bit 0, then data bits d0..d7 LSB first, then stop bit 1.
REQ-019 SHALL send the bytes of a word MSB byte first ([31:24] down to [7:0]), with the frames back-to-back and no gap between them.
REQ-020 SHALL drive datao=1 for exactly IDLE_GAP cycles after the stop bit of byte 3, then start the next word.
REQ-021 SHALL, after the last word's gap, pulse txdone for one cycle, deassert busy in that same cycle, and reset txaddr to 0.
REQ-022 SHALL hold busy=1 from the cycle after start is accepted until the txdone cycle.

Function -- receive (always armed, full duplex with transmit)
REQ-023 SHALL use receiver states RIDLE, RDATA, RSTOP, RPOST and RWAIT.
REQ-024 RIDLE: datai=0 SHALL move to RDATA; datai=1 SHALL increment the idle counter.
REQ-025 RDATA: SHALL sample datai on 8 consecutive edges into the byte shifter, LSB first, then move to RSTOP.
REQ-026 RSTOP: datai=1 SHALL place the byte into the word lane selected by bytecnt (0 to [31:24] ... 3 to [7:0]), increment bytecnt modulo 4, and move to RPOST.
REQ-027 RSTOP: datai=0 (framing error) SHALL set rxerr, clear bytecnt, and move to RWAIT.
REQ-028 On the RSTOP edge that completes byte 3, SHALL assert rxwe for one cycle with the assembled word and current rxaddr; rxaddr SHALL increment after the write.
REQ-029 RPOST: datai=0 SHALL start the next byte (to RDATA).
REQ-030 RPOST: datai=1 with bytecnt=0 SHALL go to RIDLE; datai=1 with bytecnt≠0 SHALL set rxerr, clear bytecnt, and go to RIDLE.
REQ-031 RWAIT: SHALL stay in RWAIT until datai=1, then go to RIDLE.
REQ-032 SHALL reset the idle counter on any datai=0.
REQ-033 SHALL, when the idle counter reaches TIMEOUT and at least one word was written since the last rxdone, pulse rxdone, load rxcount with rxaddr, and reset rxaddr to 0.
REQ-034 SHALL saturate the idle counter at TIMEOUT and raise no further rxdone until a new word is written.
REQ-035 SHALL wrap rxaddr modulo 2^AW with no flag.

Reset
REQ-036 SHALL, asynchronously on nrst=0, set datao=1, busy=0, txdone=0, rxdone=0, rxwe=0, rxerr=0, and txaddr, rxaddr, rxcount, rxdata, bytecnt, bit counters and idle counter to 0, with both machines idle.
REQ-037 SHALL treat reset mid-frame as aborting the frame: datao=1 immediately, and no partial word is written.

Verification
REQ-038 start, txlen=1, txdata=0x12345678, IDLE_GAP=1 -> datao cycles 1-10 = 0,0,1,0,0,1,0,0,0,1; bytes 0x34,0x56,0x78 follow; cycle 41 = 1; txdone at cycle 42.
REQ-039 datai driven with frames 0xDE,0xAD,0xBE,0xEF back-to-back, then idle -> one rxwe, rxdata=0xDEADBEEF, rxaddr=0; rxdone after 64 idle cycles; rxcount=1.
REQ-040 datai with a stop bit of 0 in byte 2 -> rxerr=1, no rxwe; the next valid word is received correctly at rxaddr=0.
REQ-041 datai idle-high after byte 1 of a word -> rxerr=1, bytecnt=0, no write.
REQ-042 start with txlen=0 -> txdone one cycle later; start while busy -> ignored; nrst pulse mid-frame -> datao=1 and all outputs at reset values.

Source files
------------

// File: rtl/uart_host.sv
// uart_host: host-side serial link model for a SoC UART pin pair.
//
// Transmit: a start pulse (accepted only while busy=0) sends txlen 32-bit
// words read from a source memory at txaddr. Each word goes out as four
// 10-bit frames (start 0, d0..d7 LSB first, stop 1), MSB byte first, frames
// back to back, followed by IDLE_GAP idle-high cycles. After the last gap
// txdone pulses, busy drops and txaddr returns to 0.
//
// Receive: always armed and independent of transmit. Frames on datai are
// assembled into words (first byte -> [31:24]) and written to a sink memory
// through rxwe/rxaddr/rxdata. A run of TIMEOUT idle-high cycles after at
// least one written word ends the burst: rxdone pulses, rxcount captures the
// number of words and rxaddr returns to 0. rxerr is sticky (framing error or
// a burst ending mid-word) and is cleared by an accepted start.
//
// Ports:
//   clk, nrst        clock (posedge), asynchronous active-low reset
//   start, txlen     transmit request pulse and word count
//   txaddr, txdata   source memory address out / word in (combinational)
//   datao, datai     serial out / in, idle level 1
//   rxwe, rxaddr, rxdata   sink memory write port
//   busy, txdone     transmit in progress / end-of-transmit pulse
//   rxdone, rxerr    end-of-receive pulse / sticky receive error
//   rxcount          words written in the last completed receive burst
module uart_host #(
    parameter int AW       = 16,
    parameter int IDLE_GAP = 1,
    parameter int TIMEOUT  = 64
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          start,
    input  logic [AW-1:0] txlen,
    output logic [AW-1:0] txaddr,
    input  logic [31:0]   txdata,
    output logic          datao,
    input  logic          datai,
    output logic          rxwe,
    output logic [AW-1:0] rxaddr,
    output logic [31:0]   rxdata,
    output logic          busy,
    output logic          txdone,
    output logic          rxdone,
    output logic          rxerr,
    output logic [AW-1:0] rxcount
);

    localparam int IW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {TIDLE, TSEND, TGAP} tstate_t;
    typedef enum logic [2:0] {RIDLE, RDATA, RSTOP, RPOST, RWAIT} rstate_t;

    // ------------------------------------------------------------------
    // Transmit machine
    // ------------------------------------------------------------------
    tstate_t       tstate;
    logic [31:0]   tword;   // current byte always sits in [31:24]
    logic [3:0]    tbit;    // frame position currently on datao (0..9)
    logic [1:0]    tbyte;   // byte of the word being sent
    logic [3:0]    tgap;    // idle cycles sent so far
    logic [AW-1:0] tleft;   // words still to finish, including current
    logic [7:0]    tcur;

    logic          tx_accept;

    assign tcur      = tword[31:24];
    assign tx_accept = start && (tstate == TIDLE);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            tstate <= TIDLE;
            tword  <= '0;
            tbit   <= '0;
            tbyte  <= '0;
            tgap   <= '0;
            tleft  <= '0;
            txaddr <= '0;
            datao  <= 1'b1;
            busy   <= 1'b0;
            txdone <= 1'b0;
        end else begin
            txdone <= 1'b0;
            case (tstate)
                TIDLE: begin
                    if (start) begin
                        if (txlen == '0) begin
                            txdone <= 1'b1;
                        end else begin
                            // This edge begins byte 0: latch word, drive start bit.
                            tword  <= txdata;
                            txaddr <= txaddr + AW'(1);
                            tleft  <= txlen;
                            tbit   <= '0;
                            tbyte  <= '0;
                            datao  <= 1'b0;
                            busy   <= 1'b1;
                            tstate <= TSEND;
                        end
                    end
                end
                TSEND: begin
                    if (tbit != 4'd9) begin
                        tbit  <= tbit + 4'd1;
                        // Next position tbit+1: data bit tbit, or stop bit at 9.
                        datao <= (tbit == 4'd8) ? 1'b1 : tcur[tbit[2:0]];
                    end else if (tbyte != 2'd3) begin
                        tbyte <= tbyte + 2'd1;
                        tword <= {tword[23:0], 8'h00};
                        tbit  <= '0;
                        datao <= 1'b0;
                    end else begin
                        tleft  <= tleft - AW'(1);
                        tgap   <= 4'd1;
                        datao  <= 1'b1;
                        tstate <= TGAP;
                    end
                end
                TGAP: begin
                    if (tgap == 4'(IDLE_GAP)) begin
                        if (tleft == '0) begin
                            txdone <= 1'b1;
                            busy   <= 1'b0;
                            txaddr <= '0;
                            tstate <= TIDLE;
                        end else begin
                            tword  <= txdata;
                            txaddr <= txaddr + AW'(1);
                            tbit   <= '0;
                            tbyte  <= '0;
                            datao  <= 1'b0;
                            tstate <= TSEND;
                        end
                    end else begin
                        tgap <= tgap + 4'd1;
                    end
                end
                default: begin
                    tstate <= TIDLE;
                    datao  <= 1'b1;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Receive machine
    // ------------------------------------------------------------------
    rstate_t       rstate;
    logic [7:0]    rshift;
    logic [2:0]    rbit;
    logic [1:0]    bytecnt;
    logic [31:0]   rword;
    logic [IW-1:0] idlecnt;
    logic          wrote;   // a word was written since the last rxdone

    logic          idle_full;
    logic          burst_end;

    assign idle_full = (idlecnt == IW'(TIMEOUT));
    assign burst_end = idle_full && wrote && (rstate == RIDLE);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rstate  <= RIDLE;
            rshift  <= '0;
            rbit    <= '0;
            bytecnt <= '0;
            rword   <= '0;
            idlecnt <= '0;
            wrote   <= 1'b0;
            rxwe    <= 1'b0;
            rxaddr  <= '0;
            rxdata  <= '0;
            rxdone  <= 1'b0;
            rxerr   <= 1'b0;
            rxcount <= '0;
        end else begin
            rxwe   <= 1'b0;
            rxdone <= 1'b0;

            // A new error in the same cycle overrides the clear below.
            if (tx_accept) begin
                rxerr <= 1'b0;
            end

            // rxaddr advances the cycle after the write it addressed.
            if (rxwe) begin
                rxaddr <= rxaddr + AW'(1);
            end else if (burst_end) begin
                rxdone  <= 1'b1;
                rxcount <= rxaddr;
                rxaddr  <= '0;
                wrote   <= 1'b0;
            end

            if (!datai) begin
                idlecnt <= '0;
            end

            case (rstate)
                RIDLE: begin
                    if (!datai) begin
                        rbit   <= '0;
                        rstate <= RDATA;
                    end else if (!idle_full) begin
                        idlecnt <= idlecnt + IW'(1);
                    end
                end
                RDATA: begin
                    rshift <= {datai, rshift[7:1]};
                    rbit   <= rbit + 3'd1;
                    if (rbit == 3'd7) begin
                        rstate <= RSTOP;
                    end
                end
                RSTOP: begin
                    if (datai) begin
                        case (bytecnt)
                            2'd0: rword[31:24] <= rshift;
                            2'd1: rword[23:16] <= rshift;
                            2'd2: rword[15:8]  <= rshift;
                            default: begin
                                rword[7:0] <= rshift;
                                rxdata     <= {rword[31:8], rshift};
                                rxwe       <= 1'b1;
                                wrote      <= 1'b1;
                            end
                        endcase
                        bytecnt <= bytecnt + 2'd1;
                        rstate  <= RPOST;
                    end else begin
                        rxerr   <= 1'b1;
                        bytecnt <= '0;
                        rstate  <= RWAIT;
                    end
                end
                RPOST: begin
                    if (!datai) begin
                        rbit   <= '0;
                        rstate <= RDATA;
                    end else begin
                        // Line went idle: a partial word is an error.
                        if (bytecnt != 2'd0) begin
                            rxerr   <= 1'b1;
                            bytecnt <= '0;
                        end
                        if (!idle_full) begin
                            idlecnt <= idlecnt + IW'(1);
                        end
                        rstate <= RIDLE;
                    end
                end
                RWAIT: begin
                    if (datai) begin
                        rstate <= RIDLE;
                    end
                end
                default: rstate <= RIDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_host.sv
module tb_uart_host;

  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          nrst;
  logic          start;
  logic [AW-1:0] txlen;
  logic [AW-1:0] txaddr;
  logic [31:0]   txdata;
  logic          datao;
  logic          datai;
  logic          rxwe;
  logic [AW-1:0] rxaddr;
  logic [31:0]   rxdata;
  logic          busy;
  logic          txdone;
  logic          rxdone;
  logic          rxerr;
  logic [AW-1:0] rxcount;

  logic [31:0]   mem [0:3];

  assign txdata = mem[txaddr[1:0]];

  uart_host #(.AW(AW), .IDLE_GAP(1), .TIMEOUT(64)) dut (
    .clk     (clk),
    .nrst    (nrst),
    .start   (start),
    .txlen   (txlen),
    .txaddr  (txaddr),
    .txdata  (txdata),
    .datao   (datao),
    .datai   (datai),
    .rxwe    (rxwe),
    .rxaddr  (rxaddr),
    .rxdata  (rxdata),
    .busy    (busy),
    .txdone  (txdone),
    .rxdone  (rxdone),
    .rxerr   (rxerr),
    .rxcount (rxcount)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard: sink-memory writes {addr, data}
  logic [47:0] exp_q[$];
  logic [47:0] got_q[$];
  int          cyc = 0;
  int          we_cyc = 0;
  int          done_cyc = 0;
  int          done_n = 0;
  logic [AW-1:0] last_cnt = '0;

  always @(negedge clk) begin
    cyc++;
    if (nrst) begin
      if (rxwe) begin
        got_q.push_back({rxaddr, rxdata});
        we_cyc = cyc;
      end
      if (rxdone) begin
        done_n++;
        last_cnt = rxcount;
        done_cyc = cyc;
      end
    end
  end

  task automatic scoreboard(input string name);
    logic [47:0] g;
    logic [47:0] e;
    check({name, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check({name, "_word"}, 64'(g), 64'(e));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    datai = b;
    step();
  endtask

  task automatic send_byte(input logic [7:0] v, input logic stopb);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
    send_bit(stopb);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  // Expected serial level in cycle c (1-based) of a burst with IDLE_GAP=1.
  function automatic logic exp_bit(input logic [31:0] w0, input logic [31:0] w1, input int c);
    int pos;
    int k;
    int by;
    int b;
    logic [31:0] w;
    pos = (c - 1) % 41;
    k   = (c - 1) / 41;
    w   = (k == 0) ? w0 : w1;
    if (pos == 40) return 1'b1;
    by = pos / 10;
    b  = pos % 10;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return w[24 - 8 * by + (b - 1)];
  endfunction

  // transmit vector table
  typedef struct {
    logic [AW-1:0] len;
    logic [31:0]   w0;
    logic [31:0]   w1;
    int            done_at;
    logic          poke;    // pulse start mid-burst; must be ignored
  } tx_vec_t;

  tx_vec_t tv[3];

  task automatic run_tx(input int vi);
    int         done_c;
    int         mism;
    logic [9:0] first10;
    tx_vec_t    v;
    v       = tv[vi];
    mem[0]  = v.w0;
    mem[1]  = v.w1;
    txlen   = v.len;
    start   = 1'b1;
    done_c  = -1;
    mism    = 0;
    first10 = '0;
    for (int c = 1; c <= v.done_at + 20; c++) begin
      step();
      if (c == 1) begin
        start = 1'b0;
        check($sformatf("tx%0d_busy_c1", vi), 64'(busy), 64'(v.len != 0));
        check($sformatf("tx%0d_txaddr_c1", vi), 64'(txaddr), (v.len != 0) ? 64'd1 : 64'd0);
      end
      if (v.poke && c == 5) begin
        start = 1'b1;
        txlen = 1;
      end
      if (v.poke && c == 6) start = 1'b0;
      if (c <= 10) first10[10 - c] = datao;
      if (c < v.done_at && datao !== exp_bit(v.w0, v.w1, c)) mism++;
      if (txdone) begin
        done_c = c;
        check($sformatf("tx%0d_busy_at_done", vi), 64'(busy), 64'd0);
        check($sformatf("tx%0d_txaddr_at_done", vi), 64'(txaddr), 64'd0);
        check($sformatf("tx%0d_datao_at_done", vi), 64'(datao), 64'd1);
        break;
      end
    end
    check($sformatf("tx%0d_done_cycle", vi), 64'(done_c), 64'(v.done_at));
    check($sformatf("tx%0d_stream_errors", vi), 64'(mism), 64'd0);
    if (vi == 0) check("tx0_first_frame", 64'(first10), 64'(10'b0010010001));
    step();
    check($sformatf("tx%0d_txdone_pulse", vi), 64'(txdone), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0] = '{16'd1, 32'h12345678, 32'h0,        42, 1'b0};
    tv[1] = '{16'd2, 32'hA5C30F01, 32'hFFFF0000, 83, 1'b1};
    tv[2] = '{16'd0, 32'hDEADDEAD, 32'h0,        1,  1'b0};

    nrst  = 1'b0;
    start = 1'b0;
    datai = 1'b1;
    txlen = '0;
    for (int i = 0; i < 4; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", 64'({datao, busy, txdone, rxdone, rxwe, rxerr}), 64'(6'b100000));
    check("reset_addr", 64'({txaddr, rxaddr, rxcount}), 64'd0);
    check("reset_rxdata", 64'(rxdata), 64'd0);
    nrst = 1'b1;
    step();

    for (int i = 0; i < 3; i++) run_tx(i);

    // one good word, then idle until the burst closes
    exp_q.push_back({16'd0, 32'hDEADBEEF});
    send_byte(8'hDE, 1'b1);
    send_byte(8'hAD, 1'b1);
    send_byte(8'hBE, 1'b1);
    send_byte(8'hEF, 1'b1);
    idle(80);
    scoreboard("rx1");
    check("rx1_done_n", 64'(done_n), 64'd1);
    check("rx1_rxcount", 64'(last_cnt), 64'd1);
    check("rx1_timeout_window", 64'((done_cyc - we_cyc >= 64) && (done_cyc - we_cyc <= 66)), 64'd1);
    check("rx1_rxaddr_after", 64'(rxaddr), 64'd0);
    check("rx1_rxerr", 64'(rxerr), 64'd0);

    // framing error in byte 2, then a clean word at address 0
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b0);
    idle(5);
    check("rx2_rxerr", 64'(rxerr), 64'd1);
    check("rx2_no_write", 64'(got_q.size()), 64'd0);
    exp_q.push_back({16'd0, 32'hCAFEF00D});
    send_byte(8'hCA, 1'b1);
    send_byte(8'hFE, 1'b1);
    send_byte(8'hF0, 1'b1);
    send_byte(8'h0D, 1'b1);
    idle(80);
    scoreboard("rx2");
    check("rx2_done_n", 64'(done_n), 64'd2);
    check("rx2_rxcount", 64'(last_cnt), 64'd1);

    // accepted start (txlen=0) clears rxerr
    txlen = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("clr_txdone", 64'(txdone), 64'd1);
    check("clr_rxerr", 64'(rxerr), 64'd0);

    // line idles after byte 1 of a word
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    idle(80);
    check("rx3_rxerr", 64'(rxerr), 64'd1);
    check("rx3_bytecnt", 64'(dut.bytecnt), 64'd0);
    check("rx3_no_write", 64'(got_q.size()), 64'd0);
    check("rx3_no_rxdone", 64'(done_n), 64'd2);

    // reset in the middle of a transmit frame and a receive word
    mem[0] = 32'h0;
    txlen  = 1;
    start  = 1'b1;
    send_bit(1'b0);
    start  = 1'b0;
    for (int i = 0; i < 8; i++) send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    check("mid_busy_before", 64'(busy), 64'd1);
    nrst = 1'b0;
    #1;
    check("mid_reset_ctrl", 64'({datao, busy, txdone, rxdone, rxwe, rxerr}), 64'(6'b100000));
    check("mid_reset_addr", 64'({txaddr, rxaddr, rxcount}), 64'd0);
    check("mid_reset_bytecnt", 64'(dut.bytecnt), 64'd0);
    step();
    nrst  = 1'b1;
    datai = 1'b1;
    idle(80);
    check("mid_no_write", 64'(got_q.size()), 64'd0);
    check("mid_no_rxdone", 64'(done_n), 64'd2);
    check("mid_datao_idle", 64'({datao, busy}), 64'(2'b10));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
